// File: rtl/dmem_map_pkg.sv
// rtl/dmem_map_pkg.sv - data-memory responder address map and register field positions
package dmem_map_pkg;

    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam logic [DEF_ADDR_W-1:0] MMIO_BASE = 12'hFF0;
    localparam int MMIO_OFF_W     = 4;

    typedef enum logic [MMIO_OFF_W-1:0] {
        OFF_CYCLE  = 4'd0,
        OFF_TXDATA = 4'd1,
        OFF_STATUS = 4'd2,
        OFF_CTRL   = 4'd3
    } mmio_off_e;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_EMPTY     = 8;
    localparam int STAT_FULL      = 9;
    localparam int STAT_OVF       = 16;

    localparam int CTRL_CLR_OVF   = 0;
    localparam int CTRL_FLUSH     = 1;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - processor dmem port plus TX stream towards the external consumer
interface dmem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output address, data, wren, out_ready,
        input  q, out_valid, out_data
    );

    modport slave (
        input  address, data, wren, out_ready,
        output q, out_valid, out_data
    );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// rtl/dmem_responder_sync_fifo.sv - TX FIFO with flush; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // When full, wr_ptr == rd_ptr: the pushed word lands in the slot being popped.
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem syncram replacement: word RAM below an MMIO window with cycle counter and TX FIFO
module dmem_responder #(
    parameter int ADDR_W                 = 12,
    parameter int DATA_W                 = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hFF0,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    import dmem_map_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] ram [0:int'(MMIO_BASE)-1];
    logic [DATA_W-1:0] cycle_cnt;
    logic              overflow;
    logic              is_ram;
    logic              in_win;
    logic [ADDR_W-1:0] off_full;
    mmio_off_e         reg_sel;
    logic              wr_tx;
    logic              wr_ctrl;
    logic              pop;
    logic              flush;
    logic              clr_ovf;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rdata;

    assign is_ram   = (bus.address < MMIO_BASE);
    assign off_full = bus.address - MMIO_BASE;
    assign in_win   = !is_ram && (off_full < ADDR_W'(16));
    assign reg_sel  = mmio_off_e'(off_full[MMIO_OFF_W-1:0]);

    assign wr_tx    = bus.wren && in_win && (reg_sel == OFF_TXDATA);
    assign wr_ctrl  = bus.wren && in_win && (reg_sel == OFF_CTRL);
    assign pop      = bus.out_valid && bus.out_ready;
    assign flush    = wr_ctrl && bus.data[CTRL_FLUSH];
    assign clr_ovf  = wr_ctrl && bus.data[CTRL_CLR_OVF];

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_tx),
        .push_data (bus.data),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;

    always_ff @(posedge clock) begin
        if (bus.wren && is_ram) begin
            ram[bus.address] <= bus.data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + DATA_W'(1);
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (wr_tx && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        status                              = '0;
        status[STAT_COUNT_LSB +: CNT_W]     = fifo_count;
        status[STAT_EMPTY]                  = fifo_empty;
        status[STAT_FULL]                   = fifo_full;
        status[STAT_OVF]                    = overflow;
    end

    // Registers read their pre-update values, matching the RAM's read-old-data behaviour.
    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram[bus.address];
        end else if (in_win) begin
            case (reg_sel)
                OFF_CYCLE:  rdata = cycle_cnt;
                OFF_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.q <= '0;
        end else begin
            bus.q <= rdata;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector table, reset corner sequence and randomized run against a queue model
module tb_dmem_responder;

    localparam logic [11:0] BASE = 12'hFF0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_responder #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .MMIO_BASE  (12'hFF0),
        .FIFO_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: sparse RAM, FIFO as a queue, counter as an edge count since reset release.
    logic [31:0] m_ram [int];
    logic [31:0] m_fifo [$];
    int unsigned m_cycle;
    bit          m_ovf;

    task automatic model_reset();
        m_fifo.delete();
        m_cycle = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic [11:0] a, input logic [31:0] d, input bit w, input bit r,
                              output logic [31:0] eq, output bit known);
        int off;
        bit pop;
        known = 1'b1;
        eq    = '0;
        off   = -1;
        if (a < BASE) begin
            if (m_ram.exists(int'(a))) eq = m_ram[int'(a)];
            else known = 1'b0;
        end else begin
            off = int'(a) - int'(BASE);
            if (off == 0) eq = m_cycle;
            else if (off == 2)
                eq = 32'(m_fifo.size()) | (m_fifo.size() == 0 ? 32'h100 : 32'h0)
                   | (m_fifo.size() == 4 ? 32'h200 : 32'h0) | (m_ovf ? 32'h1_0000 : 32'h0);
        end
        pop = r && (m_fifo.size() > 0);
        if (w && a < BASE) m_ram[int'(a)] = d;
        m_cycle++;
        if (w && off == 3 && d[1]) begin
            m_fifo.delete();
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (w && off == 1) begin
                if (m_fifo.size() < 4) m_fifo.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        if (w && off == 3 && d[0]) m_ovf = 1'b0;
    endtask

    task automatic step(input logic [11:0] a, input logic [31:0] d, input bit w, input bit r, input string tag);
        logic [31:0] eq;
        bit known;
        bus.address   = a;
        bus.data      = d;
        bus.wren      = w;
        bus.out_ready = r;
        model_edge(a, d, w, r, eq, known);
        @(posedge clock);
        #1;
        if (known) check({tag, " model q"}, bus.q, eq);
        check({tag, " model out_valid"}, 32'(bus.out_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) check({tag, " model out_data"}, bus.out_data, m_fifo[0]);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        bit          w;
        bit          r;
        bit          cq;
        logic [31:0] eq;
        bit          ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [$];

    function automatic void v(logic [11:0] a, logic [31:0] d, bit w, bit r,
                              bit cq, logic [31:0] eq, bit ev, logic [31:0] ed);
        vec_t t;
        t = '{a: a, d: d, w: w, r: r, cq: cq, eq: eq, ev: ev, ed: ed};
        tbl.push_back(t);
    endfunction

    initial begin
        bus.address   = '0;
        bus.data      = '0;
        bus.wren      = 1'b0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 4; i++) v(12'hFF4, 0, 0, 0, 1, 0, 0, 0);
        v(12'hFF0, 0, 0, 0, 1, 4, 0, 0);
        v(12'hFF4, 0, 0, 0, 1, 0, 0, 0);
        v(12'hFF4, 0, 0, 0, 1, 0, 0, 0);
        v(12'hFF0, 0, 0, 0, 1, 7, 0, 0);
        v(12'h010, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
        v(12'h010, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        v(12'h010, 1, 1, 0, 1, 32'hDEADBEEF, 0, 0);
        v(12'h010, 0, 0, 0, 1, 1, 0, 0);
        v(12'hFF1, 32'hA, 1, 0, 1, 0, 1, 32'hA);
        v(12'hFF1, 32'hB, 1, 0, 1, 0, 1, 32'hA);
        v(12'hFF1, 32'hC, 1, 0, 1, 0, 1, 32'hA);
        v(12'hFF1, 32'hD, 1, 0, 1, 0, 1, 32'hA);
        v(12'hFF2, 0, 0, 0, 1, 32'h0204, 1, 32'hA);
        v(12'hFF1, 32'hE, 1, 0, 1, 0, 1, 32'hA);
        v(12'hFF2, 0, 0, 0, 1, 32'h1_0204, 1, 32'hA);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'hB);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'hC);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'hD);
        v(12'hFF4, 0, 0, 1, 1, 0, 0, 0);
        v(12'hFF3, 1, 1, 0, 1, 0, 0, 0);
        v(12'hFF2, 0, 0, 0, 1, 32'h0100, 0, 0);
        v(12'hFF1, 32'h11, 1, 0, 1, 0, 1, 32'h11);
        v(12'hFF1, 32'h22, 1, 0, 1, 0, 1, 32'h11);
        v(12'hFF1, 32'h33, 1, 0, 1, 0, 1, 32'h11);
        v(12'hFF1, 32'h44, 1, 0, 1, 0, 1, 32'h11);
        v(12'hFF1, 32'h55, 1, 1, 1, 0, 1, 32'h22);
        v(12'hFF2, 0, 0, 0, 1, 32'h0204, 1, 32'h22);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'h33);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'h44);
        v(12'hFF4, 0, 0, 1, 1, 0, 1, 32'h55);
        v(12'hFF4, 0, 0, 1, 1, 0, 0, 0);
        v(12'hFF1, 32'h1, 1, 0, 1, 0, 1, 32'h1);
        v(12'hFF1, 32'h2, 1, 0, 1, 0, 1, 32'h1);
        v(12'hFF1, 32'h3, 1, 0, 1, 0, 1, 32'h1);
        v(12'hFF3, 32'h3, 1, 1, 1, 0, 0, 0);
        v(12'hFF2, 0, 0, 0, 1, 32'h0100, 0, 0);
        v(12'hFF1, 32'h77, 1, 0, 1, 0, 1, 32'h77);
        v(12'hFF1, 32'h88, 1, 0, 1, 0, 1, 32'h77);

        repeat (3) @(posedge clock);
        #1;
        check("reset q", bus.q, 32'h0);
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset out_data", bus.out_data, 32'h0);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r, $sformatf("vec%0d", i));
            if (tbl[i].cq) check($sformatf("vec%0d q", i), bus.q, tbl[i].eq);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) check($sformatf("vec%0d out_data", i), bus.out_data, tbl[i].ed);
        end

        // Reset mid-stream with two entries queued: outputs must drop before any clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'h0);
        check("midreset q", bus.q, 32'h0);
        check("midreset out_data", bus.out_data, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        step(12'hFF2, 0, 0, 0, "post_reset");
        check("post_reset status", bus.q, 32'h0100);

        for (int i = 0; i < 8; i++) step(12'(i), $urandom, 1, 0, "ram_init");

        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(0, 7));
            else a = BASE + 12'($urandom_range(0, 5));
            d = (a == 12'hFF3) ? 32'($urandom_range(0, 3)) : $urandom;
            step(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder side of the processor's data-memory port (address/data/wren in, q out); drop-in replacement for the dmem syncram. Provides word-addressed RAM below an MMIO window. The MMIO window holds a free-running cycle counter and a TX FIFO drained through a valid/ready stream to an external consumer (debug/UART bridge). All logic sits on the dmem clock domain.

Parameters:
ADDR_W, 12, word-address width of processor dmem port
DATA_W, 32, data width
MMIO_BASE, 12'hFF0, first MMIO word address; RAM covers 0 .. MMIO_BASE-1
FIFO_DEPTH, 4, TX FIFO entries (power of two)

Ports:
clock  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-low reset
address  input  ADDR_W  word address from processor
data  input  DATA_W  write data from processor
wren  input  1  write enable
q  output  DATA_W  registered read data
out_valid  output  1  TX stream: head entry available
out_data  output  DATA_W  TX stream: head entry
out_ready  input  1  TX stream: consumer accepts

Behaviour:
- Reset (reset low, async): q=0, cycle counter=0, FIFO empty (count=0, storage zeroed), overflow=0, out_valid=0, out_data=0. RAM contents not reset.
- Read latency 1: address sampled at rising edge N; q valid after edge N, held until next edge. q is updated every edge; a write cycle also updates q.
- RAM write: at edge with wren=1 and address<MMIO_BASE. Read-during-write same address: q returns old data.
- MMIO map (word offsets from MMIO_BASE):
  - +0 CYCLE (RO): 32-bit counter, +1 every edge, wraps 0xFFFFFFFF->0. Read returns pre-increment value at the sampling edge.
  - +1 TXDATA (WO): write pushes data into FIFO. Read returns 0.
  - +2 STATUS (RO): [3:0] count, [8] empty, [9] full, [16] overflow (sticky). Value sampled pre-update at the edge.
  - +3 CTRL (WO): bit0=1 clears overflow; bit1=1 flushes FIFO. Read returns 0.
  - +4..+15: read 0, writes ignored. Writes to RO registers ignored.
- FIFO: out_valid = count!=0; out_data = head entry (combinational from registers). Pop on edge with out_valid&out_ready.
- Push when full with no pop the same edge: data dropped, overflow set. Push when full with a pop the same edge: push accepted, count unchanged.
- Push when empty: entry visible on out_valid after that edge; no same-edge bypass.
- Flush (CTRL bit1) wins over a pop the same edge; it empties the FIFO. A push cannot coincide with a flush (single-port bus).
- Overflow clear and overflow set cannot coincide (single write per edge).
- Pointers wrap modulo FIFO_DEPTH; count is ADDR-independent, width log2(FIFO_DEPTH)+1.
- Reset asserted mid-stream: FIFO discarded immediately; out_valid drops asynchronously.

Decomposition:
- Package dmem_map_pkg: MMIO_BASE, register offsets (OFF_CYCLE=0, OFF_TXDATA=1, OFF_STATUS=2, OFF_CTRL=3), STATUS bit positions, CTRL bit positions.
- Sub-module sync_fifo (DATA_W, FIFO_DEPTH; push/pop/flush, count, full, empty, head) instantiated once. Address decode, RAM, counter and read mux stay in dmem_responder.

Test Plan:
- Reset release, read CYCLE at edge 5 after release -> q=4; read again 3 edges later -> q=7.
- Write 0xDEADBEEF to addr 0x010, then read 0x010 -> q=0xDEADBEEF one edge later. Write 0x1 to 0x010 while reading the same address -> q shows 0xDEADBEEF.
- Push 0xA,0xB,0xC,0xD with out_ready=0 -> STATUS=0x0204 (count 4, full). Fifth push 0xE -> STATUS bit16=1, count 4. Then out_ready=1 -> out_data sequence A,B,C,D, then out_valid=0.
- FIFO full with out_ready=1, push 0x55 -> one pop and push accepted, count stays 4, overflow stays 0, 0x55 emerges last.
- CTRL write 0x3 with 3 entries and out_ready=1 -> next edge count=0, out_valid=0, overflow=0.
- Assert reset with 2 entries queued -> out_valid=0, q=0 immediately. After release STATUS reads 0x0100.
